// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz raster constants, renderer colour palette and a window-compare helper.
// Pure declarations: no latency, no flow control.
package vga_timing_pkg;

  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned H_TOTAL     = 800;
  localparam int unsigned H_SYNC      = 96;
  localparam int unsigned H_ACT_START = 144;
  localparam int unsigned H_ACT_END   = 783;
  localparam int unsigned V_TOTAL     = 525;
  localparam int unsigned V_SYNC      = 2;
  localparam int unsigned V_ACT_START = 35;
  localparam int unsigned V_ACT_END   = 514;

  localparam logic [11:0] BLACK   = 12'h000;
  localparam logic [11:0] WHITE   = 12'hFFF;
  localparam logic [11:0] RED     = 12'hF00;
  localparam logic [11:0] GREEN   = 12'h0F0;
  localparam logic [11:0] BLUE    = 12'h00F;
  localparam logic [11:0] YELLOW  = 12'hFF0;
  localparam logic [11:0] CYAN    = 12'h0FF;
  localparam logic [11:0] MAGENTA = 12'hF0F;

  // Inclusive range test on a 10-bit scan coordinate.
  function automatic logic in_span(input logic [9:0] val, input int unsigned lo,
                                   input int unsigned hi);
    return (32'(val) >= lo) && (32'(val) <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: pix_en pulses one clk in every CLK_DIV, registered, the cycle after phase wraps.
// Latency: first pulse CLK_DIV cycles after reset release; free-running, no backpressure.
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam logic [1:0] PHASE_LAST = 2'(CLK_DIV - 1);

  logic [1:0] phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= 2'd0;
      pix_en <= 1'b0;
    end else begin
      pix_en <= (phase == PHASE_LAST);
      phase  <= (phase == PHASE_LAST) ? 2'd0 : phase + 2'd1;
    end
  end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster generator: scan counters, visible-window flag, frame strobe and aligned sync/colour pins.
// Latency: pins trail the scan position by one pixel; free-running, no backpressure.
module vga_scan_controller
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = vga_timing_pkg::CLK_DIV,
  parameter int unsigned H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_ACT_START = vga_timing_pkg::H_ACT_START,
  parameter int unsigned H_ACT_END   = vga_timing_pkg::H_ACT_END,
  parameter int unsigned V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_ACT_START = vga_timing_pkg::V_ACT_START,
  parameter int unsigned V_ACT_END   = vga_timing_pkg::V_ACT_END
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  vgaR,
  output logic [3:0]  vgaG,
  output logic [3:0]  vgaB
);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_TICK_ROW = 10'(V_ACT_END + 1);

  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       bright_next;
  logic       tick_arm;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  always_comb begin
    h_next = hCount + 10'd1;
    v_next = vCount;
    if (hCount == H_LAST) begin
      h_next = 10'd0;
      v_next = (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
    end
    bright_next = in_span(h_next, H_ACT_START, H_ACT_END) &&
                  in_span(v_next, V_ACT_START, V_ACT_END);
  end

  // tick_arm marks the pixel edge entering the first blanking row; frame_tick follows one clk later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCount     <= 10'd0;
      vCount     <= 10'd0;
      bright     <= 1'b0;
      tick_arm   <= 1'b0;
      frame_tick <= 1'b0;
      hSync      <= 1'b1;
      vSync      <= 1'b1;
      vgaR       <= 4'd0;
      vgaG       <= 4'd0;
      vgaB       <= 4'd0;
    end else begin
      tick_arm   <= pix_en && (h_next == 10'd0) && (v_next == V_TICK_ROW);
      frame_tick <= tick_arm;
      if (pix_en) begin
        hCount <= h_next;
        vCount <= v_next;
        bright <= bright_next;
        // Pins use the pre-update position so sync and colour stay on the same pixel.
        hSync  <= (32'(hCount) >= H_SYNC);
        vSync  <= (32'(vCount) >= V_SYNC);
        vgaR   <= bright ? rgb[11:8] : 4'd0;
        vgaG   <= bright ? rgb[7:4]  : 4'd0;
        vgaB   <= bright ? rgb[3:0]  : 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench for vga_scan_controller on a shrunken raster (80x30 total) so full frames fit the cycle budget.
// Expected positions, widths and periods are derived from the bench's own timing constants.
module tb_vga_scan_controller;

  localparam int CLK_DIV     = 4;
  localparam int H_TOTAL     = 80;
  localparam int H_SYNC      = 10;
  localparam int H_ACT_START = 14;
  localparam int H_ACT_END   = 77;
  localparam int V_TOTAL     = 30;
  localparam int V_SYNC      = 2;
  localparam int V_ACT_START = 5;
  localparam int V_ACT_END   = 24;
  localparam int FRAME_CLK   = H_TOTAL * V_TOTAL * CLK_DIV;
  localparam int BUDGET      = FRAME_CLK + 2000;

  logic        clk;
  logic        rst;
  logic [11:0] rgb;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bright;
  logic        pix_en;
  logic        frame_tick;
  logic        hSync;
  logic        vSync;
  logic [3:0]  vgaR;
  logic [3:0]  vgaG;
  logic [3:0]  vgaB;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  vga_scan_controller #(
    .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC),
    .H_ACT_START(H_ACT_START), .H_ACT_END(H_ACT_END),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC),
    .V_ACT_START(V_ACT_START), .V_ACT_END(V_ACT_END)
  ) dut (
    .clk(clk), .rst(rst), .rgb(rgb),
    .hCount(hCount), .vCount(vCount), .bright(bright),
    .pix_en(pix_en), .frame_tick(frame_tick),
    .hSync(hSync), .vSync(vSync),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_pos(input string tag, input int h, input int v);
    int k;
    k = 0;
    while (!(hCount == 10'(h) && vCount == 10'(v)) && k < BUDGET) begin
      step(1);
      k++;
    end
    check_val({"reach ", tag}, 32'(hCount == 10'(h) && vCount == 10'(v)), 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, " hCount"}, 32'(hCount), 32'd0);
    check_val({tag, " vCount"}, 32'(vCount), 32'd0);
    check_val({tag, " bright"}, 32'(bright), 32'd0);
    check_val({tag, " pix_en"}, 32'(pix_en), 32'd0);
    check_val({tag, " frame_tick"}, 32'(frame_tick), 32'd0);
    check_val({tag, " hSync"}, 32'(hSync), 32'd1);
    check_val({tag, " vSync"}, 32'(vSync), 32'd1);
    check_val({tag, " colour"}, 32'({vgaR, vgaG, vgaB}), 32'd0);
  endtask

  initial begin
    int tick_cyc;
    int k;
    int cnt;
    int hs_low, vs_low, lit, err_br, err_col, err_sync, ticks;
    logic pend, e_br, e_hs, e_vs;
    logic [11:0] e_col;

    rgb = 12'hF00;
    rst = 1'b1;
    step(3);
    check_reset_outs("reset");

    // Release on a negedge: the next posedge is edge 1.
    rst = 1'b0;
    step(3);
    check_val("pre first pix_en", 32'(pix_en), 32'd0);
    check_val("hCount before first pixel", 32'(hCount), 32'd0);
    step(1);
    check_val("first pix_en at edge 4", 32'(pix_en), 32'd1);
    check_val("hCount held during pix_en", 32'(hCount), 32'd0);
    step(1);
    check_val("pix_en one clk wide", 32'(pix_en), 32'd0);
    check_val("hCount first advance", 32'(hCount), 32'd1);
    check_val("hSync after pixel 0", 32'(hSync), 32'd0);
    check_val("vSync after row 0", 32'(vSync), 32'd0);
    step(3);
    check_val("pix_en period", 32'(pix_en), 32'd1);
    step(1);
    check_val("hCount second advance", 32'(hCount), 32'd2);

    wait_pos("line end", H_TOTAL - 1, 3);
    step(CLK_DIV);
    check_val("line wrap hCount", 32'(hCount), 32'd0);
    check_val("line wrap vCount", 32'(vCount), 32'd4);

    wait_pos("v above window", 20, V_ACT_START - 1);
    check_val("bright v=ACT_START-1", 32'(bright), 32'd0);
    wait_pos("h before window", H_ACT_START - 1, V_ACT_START);
    check_val("bright h=ACT_START-1", 32'(bright), 32'd0);
    wait_pos("h window start", H_ACT_START, V_ACT_START);
    check_val("bright h=ACT_START", 32'(bright), 32'd1);
    wait_pos("v window start", 20, V_ACT_START);
    check_val("bright v=ACT_START", 32'(bright), 32'd1);
    wait_pos("h window end", H_ACT_END, V_ACT_START);
    check_val("bright h=ACT_END", 32'(bright), 32'd1);
    wait_pos("h after window", H_ACT_END + 1, V_ACT_START);
    check_val("bright h=ACT_END+1", 32'(bright), 32'd0);

    wait_pos("line start", 0, V_ACT_START + 1);
    cnt = 0;
    for (int i = 0; i < H_TOTAL * CLK_DIV; i++) begin
      step(1);
      if (!hSync) cnt++;
    end
    check_val("hSync low clk per line", 32'(cnt), 32'(H_SYNC * CLK_DIV));

    wait_pos("v window end", 20, V_ACT_END);
    check_val("bright v=ACT_END", 32'(bright), 32'd1);

    wait_pos("tick row", 0, V_ACT_END + 1);
    check_val("frame_tick not with count", 32'(frame_tick), 32'd0);
    step(1);
    check_val("frame_tick one clk later", 32'(frame_tick), 32'd1);
    tick_cyc = cyc;
    step(1);
    check_val("frame_tick one clk wide", 32'(frame_tick), 32'd0);

    wait_pos("v below window", 20, V_ACT_END + 1);
    check_val("bright v=ACT_END+1", 32'(bright), 32'd0);

    wait_pos("frame end", H_TOTAL - 1, V_TOTAL - 1);
    step(CLK_DIV);
    check_val("frame wrap hCount", 32'(hCount), 32'd0);
    check_val("frame wrap vCount", 32'(vCount), 32'd0);

    k = 0;
    while (!frame_tick && k < BUDGET) begin
      step(1);
      k++;
    end
    check_val("frame_tick period", 32'(cyc - tick_cyc), 32'(FRAME_CLK));

    // One full frame with constant red: pins must follow the previous pixel's bright and position.
    hs_low = 0; vs_low = 0; lit = 0; err_br = 0; err_col = 0; err_sync = 0; ticks = 0;
    pend = 1'b0; e_col = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
    for (int i = 0; i < FRAME_CLK; i++) begin
      step(1);
      if (!hSync) hs_low++;
      if (!vSync) vs_low++;
      if (frame_tick) ticks++;
      if ({vgaR, vgaG, vgaB} == 12'hF00) lit++;
      if (pend) begin
        if ({vgaR, vgaG, vgaB} !== e_col) err_col++;
        if (hSync !== e_hs || vSync !== e_vs) err_sync++;
        pend = 1'b0;
      end
      if (pix_en) begin
        e_br = (hCount >= H_ACT_START) && (hCount <= H_ACT_END) &&
               (vCount >= V_ACT_START) && (vCount <= V_ACT_END);
        if (bright !== e_br) err_br++;
        e_col = bright ? 12'hF00 : 12'h000;
        e_hs  = (hCount >= H_SYNC);
        e_vs  = (vCount >= V_SYNC);
        pend  = 1'b1;
      end
    end
    check_val("bright vs window errors", 32'(err_br), 32'd0);
    check_val("colour latency errors", 32'(err_col), 32'd0);
    check_val("sync latency errors", 32'(err_sync), 32'd0);
    check_val("hSync low clk per frame", 32'(hs_low), 32'(H_SYNC * CLK_DIV * V_TOTAL));
    check_val("vSync low clk per frame", 32'(vs_low), 32'(V_SYNC * H_TOTAL * CLK_DIV));
    check_val("lit colour clk per frame", 32'(lit),
              32'((H_ACT_END - H_ACT_START + 1) * (V_ACT_END - V_ACT_START + 1) * CLK_DIV));
    check_val("frame_tick pulses per frame", 32'(ticks), 32'd1);

    wait_pos("mid frame", 40, 15);
    step(1);
    rst = 1'b1;
    #1;
    check_reset_outs("async reset");
    @(negedge clk);
    step(2);
    check_reset_outs("held reset");
    rst = 1'b0;
    step(CLK_DIV);
    check_val("restart pix_en", 32'(pix_en), 32'd1);
    check_val("restart hCount held", 32'(hCount), 32'd0);
    step(1);
    check_val("restart hCount", 32'(hCount), 32'd1);
    check_val("restart vCount", 32'(vCount), 32'd0);

    ticks = 0;
    k = 0;
    while (!(hCount == 10'(0) && vCount == 10'(V_ACT_END + 1)) && k < BUDGET) begin
      step(1);
      k++;
      if (frame_tick) ticks++;
    end
    check_val("no tick before first blanking row", 32'(ticks), 32'd0);
    check_val("reach tick row after reset", 32'(vCount), 32'(V_ACT_END + 1));
    step(1);
    check_val("tick after reset restart", 32'(frame_tick), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
